fir_line_buffer: RTL and testbench

- Raster-to-column converter directly upstream of cascade_systolic_fir.
- Accepts one pixel per clock with dv/hs/vs timing and stores the last 4 active lines in block RAM.
- Each output cycle presents the 5 vertically aligned pixels (rows y-4..y, same column) as pixel0..pixel4, plus delayed timing and a window-valid flag.
- Output feeds the FIR's pixel0..pixel4, in_valid, dv_i, hs_i and vs_i directly.

---
 rtl/fir_line_buffer.sv | 133 +++++++++++++
 tb/tb_fir_line_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fir_line_buffer.sv
// fir_line_buffer: raster-to-column converter feeding a 5-tap vertical FIR.
// Keeps the last 4 active lines in 4 rotating line banks; each accepted pixel
// produces, one cycle later, the 5 vertically aligned pixels of its column.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   dv_i/hs_i/vs_i  input timing (vs_i rising edge = frame start)
//   pixel_i         input pixel
//   dv_o/hs_o/vs_o  timing delayed by one cycle
//   pixel0..pixel4  rows y-4 (oldest) .. y (current)
//   out_valid       full 5-row column present
//   ovf             sticky line-overflow flag (cleared at frame start)
module fir_line_buffer #(
    parameter int DATA_W   = 8,
    parameter int MAX_LINE = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dv_i,
    input  logic              hs_i,
    input  logic              vs_i,
    input  logic [DATA_W-1:0] pixel_i,
    output logic              dv_o,
    output logic              hs_o,
    output logic              vs_o,
    output logic [DATA_W-1:0] pixel0,
    output logic [DATA_W-1:0] pixel1,
    output logic [DATA_W-1:0] pixel2,
    output logic [DATA_W-1:0] pixel3,
    output logic [DATA_W-1:0] pixel4,
    output logic              out_valid,
    output logic              ovf
);

    // One extra column bit so col can sit at MAX_LINE to flag overflow.
    localparam logic [ADDR_W:0] COL_MAX = (ADDR_W+1)'(MAX_LINE);

    logic [ADDR_W:0]   col_q, col_d;
    logic [1:0]        wr_sel_q, wr_sel_d;
    logic [2:0]        line_cnt_q, line_cnt_d;
    logic              ovf_q, ovf_d;
    logic              dv_q, hs_q, vs_q;
    logic              mask_q, valid_q;
    logic [1:0]        sel_q;
    logic [DATA_W-1:0] pix4_q;

    logic [DATA_W-1:0] mem [4][MAX_LINE];
    logic [DATA_W-1:0] rd_q [4];

    logic              frame_start, line_end, over, wr_en;
    logic [ADDR_W:0]   eff_col;
    logic [1:0]        eff_sel;
    logic [2:0]        eff_cnt;
    logic [ADDR_W-1:0] addr;

    always_comb begin
        frame_start = vs_i & ~vs_q;
        line_end    = dv_q & ~dv_i;
        // A pixel arriving with a frame start belongs to line 0, col 0.
        eff_col     = frame_start ? '0 : col_q;
        eff_sel     = frame_start ? '0 : wr_sel_q;
        eff_cnt     = frame_start ? '0 : line_cnt_q;
        over        = dv_i & (eff_col == COL_MAX);
        wr_en       = dv_i & ~over;
        addr        = eff_col[ADDR_W-1:0];

        col_d      = eff_col;
        wr_sel_d   = eff_sel;
        line_cnt_d = eff_cnt;
        ovf_d      = frame_start ? 1'b0 : (ovf_q | over);

        if (wr_en) begin
            col_d = eff_col + 1'b1;
        end else if (line_end && !frame_start) begin
            col_d      = '0;
            wr_sel_d   = wr_sel_q + 2'd1;
            line_cnt_d = (line_cnt_q >= 3'd4) ? 3'd4 : line_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            wr_sel_q   <= '0;
            line_cnt_q <= '0;
            ovf_q      <= 1'b0;
            dv_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            mask_q     <= 1'b0;
            valid_q    <= 1'b0;
            sel_q      <= '0;
            pix4_q     <= '0;
        end else begin
            col_q      <= col_d;
            wr_sel_q   <= wr_sel_d;
            line_cnt_q <= line_cnt_d;
            ovf_q      <= ovf_d;
            dv_q       <= dv_i;
            hs_q       <= hs_i;
            vs_q       <= vs_i;
            mask_q     <= wr_en;
            valid_q    <= wr_en & (eff_cnt >= 3'd4);
            sel_q      <= eff_sel;
            pix4_q     <= pixel_i;
        end
    end

    // Block-RAM style banks: read-before-write, no reset on the data path.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                rd_q[b] <= mem[b][addr];
                if (eff_sel == 2'(b)) begin
                    mem[b][addr] <= pixel_i;
                end
            end
        end
    end

    // The bank being written held row y-4; the others follow in rotation.
    assign pixel0    = mask_q ? rd_q[sel_q]         : '0;
    assign pixel1    = mask_q ? rd_q[sel_q + 2'd1]  : '0;
    assign pixel2    = mask_q ? rd_q[sel_q + 2'd2]  : '0;
    assign pixel3    = mask_q ? rd_q[sel_q + 2'd3]  : '0;
    assign pixel4    = pix4_q;
    assign dv_o      = dv_q;
    assign hs_o      = hs_q;
    assign vs_o      = vs_q;
    assign out_valid = valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fir_line_buffer.sv
// tb_fir_line_buffer: directed bench for fir_line_buffer.
// Instance a uses MAX_LINE=1024, instance b uses MAX_LINE=4; both share stimulus.
module tb_fir_line_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dv, hs, vs;
    logic [7:0] px;

    logic       a_dv, a_hs, a_vs, a_ov, a_ovf;
    logic [7:0] a_p0, a_p1, a_p2, a_p3, a_p4;
    logic       b_dv, b_hs, b_vs, b_ov, b_ovf;
    logic [7:0] b_p0, b_p1, b_p2, b_p3, b_p4;

    int tests = 0;
    int fails = 0;
    int bad   = 0;

    logic [39:0] capA [8];
    logic        vA   [8];
    logic [39:0] capB [8];
    logic        vB   [8];
    logic        dvB  [8];
    logic        ovfB [8];
    logic        anyv;

    always #5 clk = ~clk;

    fir_line_buffer #(.DATA_W(8), .MAX_LINE(1024), .ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst_n), .dv_i(dv), .hs_i(hs), .vs_i(vs),
        .pixel_i(px), .dv_o(a_dv), .hs_o(a_hs), .vs_o(a_vs),
        .pixel0(a_p0), .pixel1(a_p1), .pixel2(a_p2), .pixel3(a_p3),
        .pixel4(a_p4), .out_valid(a_ov), .ovf(a_ovf)
    );

    fir_line_buffer #(.DATA_W(8), .MAX_LINE(4), .ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst_n), .dv_i(dv), .hs_i(hs), .vs_i(vs),
        .pixel_i(px), .dv_o(b_dv), .hs_o(b_hs), .vs_o(b_vs),
        .pixel0(b_p0), .pixel1(b_p1), .pixel2(b_p2), .pixel3(b_p3),
        .pixel4(b_p4), .out_valid(b_ov), .ovf(b_ovf)
    );

    function automatic logic [39:0] pk(int p0, int p1, int p2, int p3, int p4);
        return {8'(p0), 8'(p1), 8'(p2), 8'(p3), 8'(p4)};
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one input cycle (called at a negedge); returns at the next
    // negedge, when outputs reflect that sample.
    task automatic step(logic d, logic h, logic v, logic [7:0] p);
        dv = d; hs = h; vs = v; px = p;
        @(negedge clk);
    endtask

    task automatic line(int row, int len, int base);
        anyv = 1'b0;
        for (int c = 0; c < len; c++) begin
            step(1'b1, 1'b0, 1'b0, 8'(base + 10*row + c));
            capA[c] = {a_p0, a_p1, a_p2, a_p3, a_p4};
            vA[c]   = a_ov;
            capB[c] = {b_p0, b_p1, b_p2, b_p3, b_p4};
            vB[c]   = b_ov;
            dvB[c]  = b_dv;
            ovfB[c] = b_ovf;
            anyv    = anyv | a_ov;
            if (a_dv !== 1'b1) bad++;
        end
        step(1'b0, 1'b1, 1'b0, 8'd0);
        if (a_dv !== 1'b0 || a_hs !== 1'b1) bad++;
        step(1'b0, 1'b0, 1'b0, 8'd0);
        if (a_hs !== 1'b0) bad++;
    endtask

    task automatic frame_start();
        step(1'b0, 1'b0, 1'b1, 8'd0);
        if (a_vs !== 1'b1) bad++;
        step(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; dv = 0; hs = 0; vs = 0; px = 0;
        repeat (2) @(negedge clk);
        chk("reset_outs",
            {a_dv, a_hs, a_vs, a_ov, a_ovf, a_p0, a_p1, a_p2, a_p3, a_p4}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame: 6 lines of 5, pixel = 10*row + col
        frame_start();
        for (int r = 0; r < 4; r++) begin
            line(r, 5, 0);
            chk($sformatf("f1_l%0d_novalid", r), anyv, 0);
        end
        line(4, 5, 0);
        chk("f1_l4c2_pix", capA[2], pk(2, 12, 22, 32, 42));
        chk("f1_l4c2_vld", vA[2], 1);
        line(5, 5, 0);
        chk("f1_l5c0_pix", capA[0], pk(10, 20, 30, 40, 50));
        chk("f1_l5c0_vld", vA[0], 1);
        chk("timing_delay", bad, 0);

        // Rotation: 9 lines of 3
        frame_start();
        for (int r = 0; r < 9; r++) line(r, 3, 0);
        chk("rot_l8c1_pix", capA[1], pk(41, 51, 61, 71, 81));
        chk("rot_l8c1_vld", vA[1], 1);

        // Frame restart after line 5: old rows must not leak in
        frame_start();
        for (int r = 0; r < 6; r++) line(r, 3, 0);
        frame_start();
        for (int r = 0; r < 4; r++) begin
            line(r, 3, 100);
            chk($sformatf("vs_l%0d_novalid", r), anyv, 0);
        end
        line(4, 3, 100);
        chk("vs_l4c0_pix", capA[0], pk(100, 110, 120, 130, 140));
        chk("vs_l4c0_vld", vA[0], 1);

        // Overflow on the MAX_LINE=4 instance
        frame_start();
        for (int r = 0; r < 4; r++) line(r, 4, 0);
        line(4, 6, 0);
        chk("ovf_c3_pix", capB[3], pk(3, 13, 23, 33, 43));
        chk("ovf_c3_vld", vB[3], 1);
        chk("ovf_c3_flag", ovfB[3], 0);
        chk("ovf_c4_pix", capB[4], pk(0, 0, 0, 0, 44));
        chk("ovf_c4_dv_vld", {dvB[4], vB[4]}, 2'b10);
        chk("ovf_c4_flag", ovfB[4], 1);
        chk("ovf_c5_pix", capB[5], pk(0, 0, 0, 0, 45));
        chk("ovf_c5_dv_vld", {dvB[5], vB[5]}, 2'b10);
        chk("ovf_blank_flag", b_ovf, 1);
        line(5, 4, 0);
        chk("ovf_next_c0_pix", capB[0], pk(10, 20, 30, 40, 50));
        chk("ovf_next_c0_vld", vB[0], 1);
        chk("ovf_next_flag", ovfB[0], 1);
        chk("ovf_a_flag", a_ovf, 0);
        step(1'b0, 1'b0, 1'b1, 8'd0);
        chk("ovf_clear_vs", b_ovf, 0);
        step(1'b0, 1'b0, 1'b0, 8'd0);

        // Asynchronous reset in the middle of line 6
        for (int r = 0; r < 6; r++) line(r, 3, 0);
        step(1'b1, 1'b0, 1'b0, 8'd60);
        step(1'b1, 1'b0, 1'b0, 8'd61);
        chk("pre_rst_vld", a_ov, 1);
        #2;
        rst_n = 1'b0; dv = 0; px = 0;
        #1;
        chk("async_rst_outs",
            {a_dv, a_hs, a_vs, a_ov, a_ovf, a_p0, a_p1, a_p2, a_p3, a_p4}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            line(r, 3, 150);
            chk($sformatf("rst_l%0d_novalid", r), anyv, 0);
        end
        line(4, 3, 150);
        chk("rst_l4c1_pix", capA[1], pk(151, 161, 171, 181, 191));
        chk("rst_l4c1_vld", vA[1], 1);

        // vs rising together with dv falling: frame start wins
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0, 8'(50 + c));
        step(1'b0, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        for (int r = 0; r < 4; r++) begin
            line(r, 3, 200);
            chk($sformatf("vsdv_l%0d_novalid", r), anyv, 0);
        end
        line(4, 3, 200);
        chk("vsdv_l4c2_pix", capA[2], pk(202, 212, 222, 232, 242));
        chk("vsdv_l4c2_vld", vA[2], 1);
        chk("timing_delay_all", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
